// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
//
// Memory-mapped 8N1 UART transmitter on the picorv32 native memory bus.
// CPU stores to DATA push bytes into a small circular FIFO; a serializer
// FSM drains the FIFO onto serialOut, LSB first. STATUS exposes FIFO level
// and busy state so firmware can poll instead of relying on write stalls.
//
// Register map (mem_addr[3:2]):
//   0 DATA   : write with mem_wstrb[0]=1 pushes mem_wdata[7:0]; reads 0
//   1 STATUS : bit0 busy, bit1 full, bit2 empty, [8+CW-1:8] count (RO)
//   2, 3     : read 0, writes ignored
//
// Parameters:
//   BAUD_DIV   : clocks per serial bit, 2..65535
//   FIFO_DEPTH : FIFO entries, power of two, 2..16
//
// Ports:
//   clk        in   system clock
//   resn       in   asynchronous active-low reset
//   enable     in   chip select from the memory decoder
//   mem_valid  in   bus request
//   mem_ready  out  one-cycle registered transfer acknowledge
//   mem_addr   in   byte address, only [3:2] decoded
//   mem_wdata  in   write data, only [7:0] used
//   mem_wstrb  in   byte strobes, all zero means read
//   mem_rdata  out  registered read data, zero whenever mem_ready is low
//   serialOut  out  registered UART TX line, idle high
// -----------------------------------------------------------------------------
module uart_tx_periph #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        serialOut
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);
  localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Bus / FIFO state
  logic            mem_ready_q;
  logic [31:0]     mem_rdata_q;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [31:0]     rdata_d;

  // Serializer state
  state_e          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [15:0]     baud_q;
  logic            serial_q;

  // Decode
  logic            accept_s;
  logic            is_read_s;
  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic            ack_s;
  logic            full_s;
  logic            empty_s;
  logic            baud_end_s;
  logic [31:0]     status_s;

  // Address and data bits outside the decoded fields are intentionally ignored.
  logic            unused_s;
  assign unused_s = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

  // Bus request decode, FIFO push/pop qualification and STATUS word.
  always_comb begin
    accept_s   = mem_valid & enable & ~mem_ready_q;
    is_read_s  = (mem_wstrb == 4'b0000);
    full_s     = (count_q == DEPTH_C);
    empty_s    = (count_q == ZERO_C);
    push_req_s = accept_s & (mem_addr[3:2] == 2'd0) & mem_wstrb[0];
    // A push against a full FIFO is held off (no ack) and retried next cycle;
    // a same-cycle pop only frees the slot once count_q has updated.
    push_s     = push_req_s & ~full_s;
    ack_s      = accept_s & ~(push_req_s & full_s);
    pop_s      = (state_q == ST_IDLE) & ~empty_s;
    baud_end_s = (baud_q == BAUD_LAST);

    status_s            = 32'd0;
    status_s[0]         = (state_q != ST_IDLE) | ~empty_s;
    status_s[1]         = full_s;
    status_s[2]         = empty_s;
    status_s[8 +: CW]   = count_q;
  end

  // Next-state for read data and FIFO occupancy.
  always_comb begin
    if (ack_s && is_read_s && (mem_addr[3:2] == 2'd1)) begin
      rdata_d = status_s;
    end else begin
      rdata_d = 32'd0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Bus acknowledge, read data register and FIFO storage/pointers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
      wptr_q      <= {AW{1'b0}};
      rptr_q      <= {AW{1'b0}};
      count_q     <= ZERO_C;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 8'd0;
      end
    end else begin
      mem_ready_q <= ack_s;
      mem_rdata_q <= rdata_d;
      count_q     <= count_d;
      if (push_s) begin
        fifo_q[wptr_q] <= mem_wdata[7:0];
        wptr_q         <= wptr_q + PTR_ONE_C;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_ONE_C;
      end
    end
  end

  // Serializer FSM. serialOut is registered from the current state, so the
  // line trails the state by one clock; every bit keeps its full length.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      serial_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          serial_q <= 1'b1;
          if (pop_s) begin
            shift_q   <= fifo_q[rptr_q];
            bit_cnt_q <= 3'd0;
            baud_q    <= 16'd0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          serial_q <= 1'b0;
          if (baud_end_s) begin
            baud_q    <= 16'd0;
            bit_cnt_q <= 3'd0;
            state_q   <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          serial_q <= shift_q[0];
          if (baud_end_s) begin
            baud_q  <= 16'd0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          serial_q <= 1'b1;
          if (baud_end_s) begin
            baud_q  <= 16'd0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          serial_q <= 1'b1;
          baud_q   <= 16'd0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign serialOut = serial_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
//
// Directed sequence with random data against uart_tx_periph (BAUD_DIV=4,
// FIFO_DEPTH=8). A line receiver decodes every frame from serialOut and
// compares it against the queue of bytes the bench has pushed; STATUS values
// are derived from pushed bytes minus frames seen on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

  localparam int BD    = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        resn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_rdata;
  logic        serialOut;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_periph #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resn      (resn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .serialOut (serialOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected STATUS word from the documented field layout.
  function automatic logic [31:0] status_exp(input int cnt, input bit busy);
    logic [31:0] w;
    w       = 32'd0;
    w[0]    = busy;
    w[1]    = (cnt == DEPTH);
    w[2]    = (cnt == 0);
    w[11:8] = 4'(cnt);
    return w;
  endfunction

  // One bus transfer; lat = edges from request to acknowledge, acc = cyc of the
  // accepting edge.
  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output int lat, output int acc);
    if (mem_ready) begin
      @(posedge clk); #1;
    end
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_valid = 1'b1;
    enable    = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 2000);
    rdata     = mem_rdata;
    acc       = cyc;
    mem_valid = 1'b0;
    enable    = 1'b0;
    mem_wstrb = 4'd0;
    chk("bus_timeout", 32'(mem_ready), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Line receiver: samples on the falling clock edge, checks each bit is stable
  // for BD clocks, reconstructs the byte LSB first and matches it in order.
  initial begin
    logic [7:0] rx;
    bit glitch;
    bit aborted;
    int b;
    forever begin
      @(negedge clk);
      if (mon_en && resn && serialOut === 1'b0) begin
        start_q.push_back(cyc);
        rx = 8'd0;
        glitch = 1'b0;
        aborted = 1'b0;
        for (int s = 1; s < FRAME; s++) begin
          @(negedge clk);
          if (!mon_en) begin
            aborted = 1'b1;
            break;
          end
          b = s / BD;
          if (b == 0) begin
            if (serialOut !== 1'b0) glitch = 1'b1;
          end else if (b == 9) begin
            if (serialOut !== 1'b1) glitch = 1'b1;
          end else if (s % BD == 0) begin
            rx[b-1] = serialOut;
          end else if (serialOut !== rx[b-1]) begin
            glitch = 1'b1;
          end
        end
        if (!aborted) begin
          chk("frame_shape", 32'(glitch), 32'd0);
          chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  wb;
    int lat;
    int acc;
    int lat_a[10];
    int acc_a[10];
    int sent;
    int iter;
    int cnt;
    bit ok;

    // Reset held with random bus activity.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mem_valid = 1'($urandom_range(0, 1));
      enable    = 1'($urandom_range(0, 1));
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
      chk("rst_serial", 32'(serialOut), 32'd1);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
    end
    mem_valid = 1'b0;
    enable    = 1'b0;
    @(posedge clk); #1;
    resn = 1'b1;
    @(posedge clk); #1;
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("rst_status", rd, status_exp(0, 1'b0));
    chk("status_latency", 32'(lat), 32'd1);

    // Single byte 0xA5.
    start_q.delete();
    exp_q.push_back(8'hA5);
    bus_access(32'h0, 32'h0000_00A5, 4'b0001, rd, lat, acc);
    chk("single_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(mem_ready), 32'd0);
    wait_drain("single_drain");
    chk("single_frames", 32'(start_q.size()), 32'd1);
    chk("first_start_delay", 32'(start_q[0] - acc), 32'd2);
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("single_status_idle", rd, status_exp(0, 1'b0));

    // Fill and stall: 10 back-to-back writes. Byte 0 leaves the FIFO at once,
    // so the FIFO is full after the 9th push and the 10th write stalls until
    // byte 1 is popped at the end of frame 0.
    start_q.delete();
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(8'(k));
      bus_access(32'h0, 32'(k), 4'b0001, rd, lat_a[k], acc_a[k]);
      if (k == DEPTH) begin
        bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
        chk("fill_status_full", rd, status_exp(k + 1 - start_q.size(), 1'b1));
      end
    end
    for (int k = 0; k <= DEPTH; k++) begin
      chk("fill_immediate_ack", 32'(lat_a[k]), 32'd1);
    end
    chk("fill_stalled", 32'(lat_a[DEPTH+1] > 1), 32'd1);
    wait_drain("fill_drain");
    chk("fill_frames", 32'(start_q.size()), 32'd10);
    chk("stall_release", 32'(acc_a[DEPTH+1]), 32'(start_q[1]));
    for (int k = 1; k < 10; k++) begin
      chk("frame_gap", 32'(start_q[k] - start_q[k-1]), 32'(FRAME + 1));
    end
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("fill_status_idle", rd, status_exp(0, 1'b0));

    // Wrap-around: 20 random bytes with polling on full.
    sent = 0;
    iter = 0;
    while (sent < 20 && iter < 3000) begin
      bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
      cnt = int'(rd[11:8]);
      chk("wrap_count_bound", 32'(cnt <= DEPTH), 32'd1);
      chk("wrap_full_flag", 32'(rd[1]), 32'(cnt == DEPTH));
      if (!rd[1]) begin
        wb = 8'($urandom);
        exp_q.push_back(wb);
        bus_access(32'h0, {24'($urandom), wb}, 4'b0001, rd, lat, acc);
        sent++;
      end
      iter++;
    end
    chk("wrap_all_sent", 32'(sent), 32'd20);
    wait_drain("wrap_drain");
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("wrap_status_idle", rd, status_exp(0, 1'b0));

    // Strobe and address decode.
    start_q.delete();
    bus_access(32'h0, 32'h0000_0055, 4'b0010, rd, lat, acc);
    chk("strobe_ack_latency", 32'(lat), 32'd1);
    chk("strobe_rdata", rd, 32'd0);
    bus_access(32'h8, 32'h0000_0066, 4'b1111, rd, lat, acc);
    chk("off8_ack_latency", 32'(lat), 32'd1);
    bus_access(32'h4, 32'h0000_0077, 4'b1111, rd, lat, acc);
    chk("status_write_rdata", rd, 32'd0);
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("strobe_status", rd, status_exp(0, 1'b0));
    bus_access(32'h0, 32'd0, 4'b0000, rd, lat, acc);
    chk("data_read_zero", rd, 32'd0);
    bus_access(32'hC, 32'd0, 4'b0000, rd, lat, acc);
    chk("offc_read_zero", rd, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (serialOut !== 1'b1) ok = 1'b0;
    end
    chk("strobe_line_idle", 32'(ok), 32'd1);
    chk("strobe_no_frames", 32'(start_q.size()), 32'd0);

    // Decode: valid without enable for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      mem_valid = 1'b1;
      enable    = 1'b0;
      mem_addr  = {28'd0, 2'($urandom), 2'b00};
      mem_wstrb = 4'($urandom);
      mem_wdata = $urandom;
      @(posedge clk); #1;
      chk("decode_ready", 32'(mem_ready), 32'd0);
      chk("decode_rdata", mem_rdata, 32'd0);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("decode_status", rd, status_exp(0, 1'b0));

    // Reset mid-frame aborts the frame and flushes the FIFO.
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    bus_access(32'h0, 32'h0000_003C, 4'b0001, rd, lat, acc);
    bus_access(32'h0, 32'h0000_00C3, 4'b0001, rd, lat, acc);
    repeat (15) @(posedge clk);
    mon_en = 1'b0;
    #3;
    resn = 1'b0;
    #1;
    chk("midrst_serial", 32'(serialOut), 32'd1);
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    resn = 1'b1;
    exp_q.delete();
    start_q.delete();
    mon_en = 1'b1;
    bus_access(32'h4, 32'd0, 4'b0000, rd, lat, acc);
    chk("midrst_status", rd, status_exp(0, 1'b0));
    ok = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (serialOut !== 1'b1) ok = 1'b0;
    end
    chk("midrst_line_idle", 32'(ok), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
